// File: rtl/router_fsm.sv
// Packet controller for the 1x3 router: header decode, load sequencing, full-FIFO stall.
// Optional ROUTER_FSM_DEBUG_EN exposes the raw state register on state_dbg.
//
// state | meaning
// DA    | decode header address, idle
// LFD   | write header byte
// LD    | write payload bytes
// FFS   | destination FIFO full, stall
// LAF   | resume after full
// LP    | write parity byte
// CPE   | check parity, reset internal regs
// WTE   | wait for destination FIFO to drain
module router_fsm (
  input  logic       clock,
  input  logic       resetn,
  input  logic       pkt_valid,
  input  logic [1:0] data_in,
  input  logic       fifo_full,
  input  logic       fifo_empty_0,
  input  logic       fifo_empty_1,
  input  logic       fifo_empty_2,
  input  logic       soft_reset_0,
  input  logic       soft_reset_1,
  input  logic       soft_reset_2,
  input  logic       parity_done,
  input  logic       low_pkt_valid,
  output logic       detect_add,
  output logic       lfd_state,
  output logic       ld_state,
  output logic       laf_state,
  output logic       full_state,
  output logic       rst_int_reg,
  output logic       write_enb_reg,
  output logic       busy
`ifdef ROUTER_FSM_DEBUG_EN
  ,
  output logic [2:0] state_dbg
`endif
);

  typedef enum logic [2:0] {
    DA  = 3'd0,
    LFD = 3'd1,
    LD  = 3'd2,
    FFS = 3'd3,
    LAF = 3'd4,
    LP  = 3'd5,
    CPE = 3'd6,
    WTE = 3'd7
  } state_t;

  state_t     state_q, state_d;
  logic [1:0] addr_q;
  logic       hdr_valid;
  logic       hdr_empty;
  logic       sel_empty;
  logic       sel_soft_reset;

  assign hdr_valid = pkt_valid && (data_in != 2'd3);

  // Address 3 never selects a destination, so it reads as not-empty / no soft reset.
  always_comb begin
    hdr_empty      = 1'b0;
    sel_empty      = 1'b0;
    sel_soft_reset = 1'b0;
    case (data_in)
      2'd0:    hdr_empty = fifo_empty_0;
      2'd1:    hdr_empty = fifo_empty_1;
      2'd2:    hdr_empty = fifo_empty_2;
      default: hdr_empty = 1'b0;
    endcase
    case (addr_q)
      2'd0:    begin sel_empty = fifo_empty_0; sel_soft_reset = soft_reset_0; end
      2'd1:    begin sel_empty = fifo_empty_1; sel_soft_reset = soft_reset_1; end
      2'd2:    begin sel_empty = fifo_empty_2; sel_soft_reset = soft_reset_2; end
      default: begin sel_empty = 1'b0;         sel_soft_reset = 1'b0;         end
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= DA;
      addr_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      if (state_q == DA && hdr_valid)
        addr_q <= data_in;
    end
  end

  always_comb begin
    state_d = state_q;
    if (state_q != DA && sel_soft_reset) begin
      state_d = DA;
    end else begin
      case (state_q)
        DA:      if (hdr_valid) state_d = hdr_empty ? LFD : WTE;
        LFD:     state_d = LD;
        LD:      if (fifo_full) state_d = FFS;
                 else if (!pkt_valid) state_d = LP;
        FFS:     if (!fifo_full) state_d = LAF;
        LAF:     if (parity_done) state_d = DA;
                 else if (low_pkt_valid) state_d = LP;
                 else state_d = LD;
        LP:      state_d = CPE;
        CPE:     state_d = fifo_full ? FFS : DA;
        WTE:     if (sel_empty) state_d = LFD;
        default: state_d = DA;
      endcase
    end
  end

  always_comb begin
    detect_add    = (state_q == DA);
    lfd_state     = (state_q == LFD);
    ld_state      = (state_q == LD);
    laf_state     = (state_q == LAF);
    full_state    = (state_q == FFS);
    rst_int_reg   = (state_q == CPE);
    write_enb_reg = (state_q == LD) || (state_q == LAF) || (state_q == LP);
    busy          = !((state_q == DA) || (state_q == LD));
  end

`ifdef ROUTER_FSM_DEBUG_EN
  assign state_dbg = state_q;
`endif

endmodule

// File: tb/tb_router_fsm.sv
// Scoreboard bench for router_fsm: directed packet scenarios then randomized traffic
// against a behavioural packet model; a monitor compares strobes after every clock edge.
module tb_router_fsm;

  logic clock = 1'b0;
  logic resetn;
  logic pkt_valid, fifo_full, parity_done, low_pkt_valid;
  logic [1:0] data_in;
  logic fifo_empty_0, fifo_empty_1, fifo_empty_2;
  logic soft_reset_0, soft_reset_1, soft_reset_2;
  logic detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic write_enb_reg, busy;
`ifdef ROUTER_FSM_DEBUG_EN
  logic [2:0] state_dbg;
`endif

  router_fsm dut (
    .clock(clock), .resetn(resetn), .pkt_valid(pkt_valid), .data_in(data_in),
    .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
    .fifo_empty_2(fifo_empty_2), .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1),
    .soft_reset_2(soft_reset_2), .parity_done(parity_done), .low_pkt_valid(low_pkt_valid),
    .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
    .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
    .write_enb_reg(write_enb_reg), .busy(busy)
`ifdef ROUTER_FSM_DEBUG_EN
    , .state_dbg(state_dbg)
`endif
  );

  always #5 clock = ~clock;

  typedef enum int {M_DA, M_LFD, M_LD, M_FFS, M_LAF, M_LP, M_CPE, M_WTE} phase_t;
  typedef struct {
    logic [7:0] outs;
    phase_t     ph;
  } exp_t;

  exp_t   sb_q[$];
  phase_t m_ph = M_DA;
  int     m_dest = 0;
  int     checks = 0;
  int     failures = 0;

  // Expected strobes in the order {detect_add,lfd,ld,laf,full,rst_int,write_enb,busy}.
  function automatic logic [7:0] expect_outs(phase_t p);
    logic wr, stall;
    wr    = (p == M_LD) || (p == M_LAF) || (p == M_LP);
    stall = !((p == M_DA) || (p == M_LD));
    return {p == M_DA, p == M_LFD, p == M_LD, p == M_LAF, p == M_FFS, p == M_CPE, wr, stall};
  endfunction

  function automatic logic [7:0] dut_outs();
    return {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
            write_enb_reg, busy};
  endfunction

  task automatic check8(string name, logic [7:0] act, logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  // Packet-level model: what the controller should be doing next given this cycle's inputs.
  task automatic model_step();
    logic [2:0] empty, sreset;
    empty  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
    sreset = {soft_reset_2, soft_reset_1, soft_reset_0};
    if (!resetn) begin
      m_ph = M_DA;
      m_dest = 0;
      return;
    end
    if (m_ph != M_DA && sreset[m_dest]) begin
      m_ph = M_DA;
      return;
    end
    case (m_ph)
      M_DA: if (pkt_valid && data_in != 2'd3) begin
              m_dest = int'(data_in);
              m_ph = empty[m_dest] ? M_LFD : M_WTE;
            end
      M_LFD: m_ph = M_LD;
      M_LD:  m_ph = fifo_full ? M_FFS : (!pkt_valid ? M_LP : M_LD);
      M_FFS: m_ph = fifo_full ? M_FFS : M_LAF;
      M_LAF: m_ph = parity_done ? M_DA : (low_pkt_valid ? M_LP : M_LD);
      M_LP:  m_ph = M_CPE;
      M_CPE: m_ph = fifo_full ? M_FFS : M_DA;
      M_WTE: if (empty[m_dest]) m_ph = M_LFD;
      default: m_ph = M_DA;
    endcase
  endtask

  // Called at a falling edge with inputs already set: predict, enqueue, advance one cycle.
  task automatic tick();
    exp_t e;
    model_step();
    e.outs = expect_outs(m_ph);
    e.ph   = m_ph;
    sb_q.push_back(e);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    pkt_valid = 0; data_in = 0; fifo_full = 0; parity_done = 0; low_pkt_valid = 0;
    fifo_empty_0 = 1; fifo_empty_1 = 1; fifo_empty_2 = 1;
    soft_reset_0 = 0; soft_reset_1 = 0; soft_reset_2 = 0;
  endtask

  task automatic header(input logic [1:0] a);
    pkt_valid = 1; data_in = a; tick();
    tick();
  endtask

  always begin
    exp_t e;
    @(posedge clock);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check8($sformatf("outputs(%s)", e.ph.name()), dut_outs(), e.outs);
`ifdef ROUTER_FSM_DEBUG_EN
      check8("state_dbg", {5'd0, state_dbg}, 8'(int'(e.ph)));
`endif
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    resetn = 0;
    idle_inputs();
    #12;
    check8("reset_outputs", dut_outs(), 8'b1000_0000);
    @(negedge clock);
    resetn = 1;

    // Good packet to destination 1: DA,LFD,LD x4,LP,CPE,DA.
    header(2'd1);
    repeat (3) tick();
    pkt_valid = 0;
    repeat (3) tick();

    // Destination 2 busy for three cycles.
    fifo_empty_2 = 0;
    pkt_valid = 1; data_in = 2'd2; tick();
    tick(); tick();
    fifo_empty_2 = 1; tick();
    tick();
    pkt_valid = 0; repeat (3) tick();

    // FIFO full in LD, then LAF -> LD / LP / DA.
    for (int k = 0; k < 3; k++) begin
      header(2'd0);
      fifo_full = 1; repeat (3) tick();
      fifo_full = 0; tick();
      low_pkt_valid = (k == 1); parity_done = (k == 2); tick();
      low_pkt_valid = 0; parity_done = 0;
      pkt_valid = 0; repeat (3) tick();
    end

    // Soft reset of selected destination aborts; non-selected is ignored.
    header(2'd0);
    soft_reset_1 = 1; tick(); soft_reset_1 = 0;
    soft_reset_0 = 1; tick(); soft_reset_0 = 0;
    tick();
    // Soft reset and full together in LD.
    header(2'd2);
    soft_reset_2 = 1; fifo_full = 1; tick();
    soft_reset_2 = 0; fifo_full = 0; tick();
    // Parity write fills the FIFO in CPE.
    header(2'd1);
    pkt_valid = 0; tick(); tick();
    fifo_full = 1; tick(); tick();
    fifo_full = 0; tick(); parity_done = 1; tick(); parity_done = 0;

    // Invalid address stays in DA.
    pkt_valid = 1; data_in = 2'd3; repeat (2) tick();
    pkt_valid = 0;

    // Asynchronous reset between edges while in LD.
    header(2'd1);
    #2;
    resetn = 0;
    #1;
    check8("async_reset_mid_ld", {detect_add, ld_state, write_enb_reg, busy}, 8'b0000_1000);
`ifdef ROUTER_FSM_DEBUG_EN
    check8("async_reset_state_dbg", {5'd0, state_dbg}, 8'd0);
`endif
    tick();
    resetn = 1;
    idle_inputs();
    tick();

    // Randomized traffic.
    for (int n = 0; n < 3000; n++) begin
      pkt_valid     = ($urandom_range(0, 3) != 0);
      data_in       = 2'($urandom_range(0, 3));
      fifo_full     = ($urandom_range(0, 3) == 0);
      fifo_empty_0  = ($urandom_range(0, 4) > 1);
      fifo_empty_1  = ($urandom_range(0, 4) > 1);
      fifo_empty_2  = ($urandom_range(0, 4) > 1);
      soft_reset_0  = ($urandom_range(0, 29) == 0);
      soft_reset_1  = ($urandom_range(0, 29) == 0);
      soft_reset_2  = ($urandom_range(0, 29) == 0);
      parity_done   = ($urandom_range(0, 4) == 0);
      low_pkt_valid = ($urandom_range(0, 2) == 0);
      resetn        = ($urandom_range(0, 199) != 0);
      tick();
    end
    resetn = 1;
    idle_inputs();
    repeat (3) @(negedge clock);
    checks++;
    if (sb_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
